// File: rtl/cal_hu_deadlock_pkg.sv
// cal_hu_deadlock_pkg: shared state encoding and defaults for the CAL_Hu deadlock reporter
package cal_hu_deadlock_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    REPORT  = 2'd2,
    HALT    = 2'd3
  } state_t;
  localparam int DEF_THRESH = 1024;
endpackage

// File: rtl/cal_hu_deadlock_prio_enc.sv
// cal_hu_deadlock_prio_enc: index of the lowest set monitor block bit
module cal_hu_deadlock_prio_enc #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_MON-1:0] mon_block,
  output logic [IDX_W-1:0]   lo_idx
);
  always_comb begin
    lo_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) if (mon_block[i]) lo_idx = IDX_W'(i);
  end
endmodule

// File: rtl/cal_hu_hls_deadlock_reporter.sv
// cal_hu_hls_deadlock_reporter: confirms persistent monitor blocking and reports it once
module cal_hu_hls_deadlock_reporter
  import cal_hu_deadlock_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int THRESH  = DEF_THRESH,
  parameter int CNT_W   = 16,
  parameter int CYC_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               all_idle,
  input  logic               clear,
  output logic               report_valid,
  input  logic               report_ready,
  output logic [IDX_W-1:0]   report_idx,
  output logic [CYC_W-1:0]   report_cycles,
  output logic               deadlock_flag
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CYC_W-1:0] cyc;
  logic [IDX_W-1:0] lo_idx;
  logic hold, confirm;
  cal_hu_deadlock_prio_enc #(.NUM_MON(NUM_MON), .IDX_W(IDX_W)) u_enc (
    .mon_block (mon_block),
    .lo_idx    (lo_idx)
  );
  assign hold          = |mon_block & !all_idle;
  assign confirm       = state == SUSPECT && hold && cnt == CNT_W'(THRESH - 1);
  assign report_valid  = state == REPORT;
  assign deadlock_flag = state == HALT;
  always_comb begin
    state_nxt = clear                ? IDLE :
                state == IDLE        ? (hold ? SUSPECT : IDLE) :
                state == SUSPECT     ? (!hold ? IDLE : confirm ? REPORT : SUSPECT) :
                state == REPORT      ? (report_ready ? HALT : REPORT) :
                HALT;
  end
  // the cycle stamp saturates rather than wrapping so late reports never look early
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cyc           <= '0;
      report_idx    <= '0;
      report_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= state_nxt == IDLE ? '0 :
               state == IDLE ? CNT_W'(1) :
               (state == SUSPECT && !confirm) ? cnt + CNT_W'(1) : cnt;
      cyc   <= &cyc ? cyc : cyc + CYC_W'(1);
      if (confirm && !clear) begin
        report_idx    <= lo_idx;
        report_cycles <= cyc;
      end
    end
  end
endmodule

// File: tb/tb_cal_hu_hls_deadlock_reporter.sv
// tb_cal_hu_hls_deadlock_reporter: directed table plus randomized run against a behavioural model
module tb_cal_hu_hls_deadlock_reporter;
  localparam int TH = 8;
  typedef struct {
    logic [3:0] b;
    bit         idl, clr, rdy, rst;
    int         n;
    bit         ev, ef;
    logic [1:0] ei;
  } vec_t;
  logic clock = 0, reset = 1, all_idle = 0, clear = 0, report_ready = 0;
  logic [3:0] mon_block = '0;
  logic report_valid, deadlock_flag, rv2, df2;
  logic [1:0] report_idx, idx2;
  logic [31:0] report_cycles;
  logic [2:0] cyc2;
  int n_chk = 0, n_fail = 0;
  int run = 0, midx = 0;
  bit pend = 0, flag = 0;
  longint mcyc = 0, mstamp = 0;
  vec_t tbl[$];
  always #5 clock = ~clock;
  cal_hu_hls_deadlock_reporter #(.NUM_MON(4), .IDX_W(2), .THRESH(TH), .CNT_W(16), .CYC_W(32)) dut (
    .clock(clock), .reset(reset), .mon_block(mon_block), .all_idle(all_idle), .clear(clear),
    .report_valid(report_valid), .report_ready(report_ready), .report_idx(report_idx),
    .report_cycles(report_cycles), .deadlock_flag(deadlock_flag)
  );
  // narrow stamp instance exposes cycle-counter saturation
  cal_hu_hls_deadlock_reporter #(.NUM_MON(4), .IDX_W(2), .THRESH(TH), .CNT_W(16), .CYC_W(3)) dut_sat (
    .clock(clock), .reset(reset), .mon_block(mon_block), .all_idle(all_idle), .clear(clear),
    .report_valid(rv2), .report_ready(report_ready), .report_idx(idx2),
    .report_cycles(cyc2), .deadlock_flag(df2)
  );
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic int lowest(input logic [3:0] b);
    for (int i = 0; i < 4; i++) if (b[i]) return i;
    return 0;
  endfunction
  task automatic step(input logic [3:0] b, input bit idl, input bit clr, input bit rdy, input bit rst);
    mon_block = b; all_idle = idl; clear = clr; report_ready = rdy; reset = rst;
    @(posedge clock);
    if (rst) begin
      run = 0; pend = 0; flag = 0; midx = 0; mcyc = 0; mstamp = 0;
    end else begin
      if (clr) begin
        run = 0; pend = 0; flag = 0;
      end else if (pend) begin
        if (rdy) begin pend = 0; flag = 1; end
      end else if (!flag) begin
        if (b != 0 && !idl) begin
          run++;
          if (run == TH) begin pend = 1; run = 0; midx = lowest(b); mstamp = mcyc; end
        end else run = 0;
      end
      if (mcyc < 64'hFFFF_FFFF) mcyc++;
    end
    #1;
    chk("valid", report_valid, pend);
    chk("flag", deadlock_flag, flag);
    chk("idx", report_idx, midx);
    chk("stamp", report_cycles, mstamp);
    chk("sat_valid", rv2, pend);
    chk("sat_flag", df2, flag);
    chk("sat_idx", idx2, midx);
    chk("sat_stamp", cyc2, mstamp > 7 ? 7 : mstamp);
  endtask
  task automatic add(input logic [3:0] b, input bit idl, input bit clr, input bit rdy, input bit rst,
                     input int n, input bit ev, input bit ef, input logic [1:0] ei);
    vec_t v;
    v.b = b; v.idl = idl; v.clr = clr; v.rdy = rdy; v.rst = rst;
    v.n = n; v.ev = ev; v.ef = ef; v.ei = ei;
    tbl.push_back(v);
  endtask
  initial begin
    add(4'b0000, 0, 0, 0, 1, 2, 0, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 7, 0, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 1, 1, 0, 2);
    add(4'b0100, 0, 0, 1, 0, 1, 0, 1, 2);
    add(4'b0000, 0, 1, 0, 0, 1, 0, 0, 2);
    add(4'b1111, 0, 0, 0, 0, 7, 0, 0, 2);
    add(4'b0000, 0, 0, 0, 0, 1, 0, 0, 2);
    add(4'b0001, 0, 0, 0, 0, 7, 0, 0, 2);
    add(4'b0001, 0, 0, 0, 0, 1, 1, 0, 0);
    add(4'b0000, 0, 1, 0, 0, 1, 0, 0, 0);
    add(4'b1010, 0, 0, 0, 0, 7, 0, 0, 0);
    add(4'b1010, 0, 0, 0, 0, 1, 1, 0, 1);
    add(4'b0000, 1, 0, 0, 0, 5, 1, 0, 1);
    add(4'b0000, 0, 0, 1, 0, 1, 0, 1, 1);
    add(4'b1111, 0, 0, 1, 0, 10, 0, 1, 1);
    add(4'b0000, 0, 1, 0, 0, 1, 0, 0, 1);
    add(4'b0001, 0, 0, 0, 0, 5, 0, 0, 1);
    add(4'b0001, 1, 0, 0, 0, 1, 0, 0, 1);
    add(4'b0001, 0, 0, 0, 0, 7, 0, 0, 1);
    add(4'b0001, 0, 0, 0, 0, 1, 1, 0, 0);
    add(4'b0001, 0, 1, 1, 0, 1, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0, 1, 0, 0, 0);
    add(4'b0100, 0, 0, 0, 0, 8, 1, 0, 2);
    add(4'b0100, 0, 0, 1, 0, 1, 0, 1, 2);
    add(4'b0100, 0, 0, 0, 1, 1, 0, 0, 0);
    add(4'b0000, 0, 0, 0, 0, 10, 0, 0, 0);
    add(4'b0010, 0, 0, 0, 0, 8, 1, 0, 1);
    add(4'b0000, 0, 0, 1, 0, 1, 0, 1, 1);
    foreach (tbl[r]) begin
      for (int k = 0; k < tbl[r].n; k++) step(tbl[r].b, tbl[r].idl, tbl[r].clr, tbl[r].rdy, tbl[r].rst);
      chk($sformatf("row%0d_valid", r), report_valid, tbl[r].ev);
      chk($sformatf("row%0d_flag", r), deadlock_flag, tbl[r].ef);
      chk($sformatf("row%0d_idx", r), report_idx, tbl[r].ei);
    end
    chk("restamp_after_reset", report_cycles, 17);
    chk("saturated_stamp", cyc2, 7);
    step(4'b0000, 0, 0, 0, 1);
    for (int k = 0; k < 1500; k++) begin
      logic [3:0] b;
      b = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      step(b, $urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
